pc_gen: RTL and testbench

Parametrised fetch-PC generator for the RISC-V core. It replaces the plain "pc+4 or pc+imm" next-PC mux with a registered PC, stall and redirect control, and full RV32I branch/jump resolution. It adds a direct-mapped branch target buffer (BTB) with 2-bit saturating counters, and traps misaligned targets. It sits between the execute stage, which supplies resolved control-flow results, and the instruction-fetch stage, which consumes `pc` and the prediction.

---
 rtl/pc_gen.sv | 167 ++++++++++++++++
 tb/tb_pc_gen.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// Fetch-PC generator: registered PC with stall/redirect, RV32I branch/jump
// resolution, misalignment trap and a direct-mapped BTB with 2-bit counters.
module pc_gen #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [XLEN-1:0] TRAP_PC   = XLEN'(32'h0000_0100),
  parameter int              BTB_DEPTH = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            ex_is_branch,
  input  logic            ex_is_jal,
  input  logic            ex_is_jalr,
  input  logic [2:0]      ex_branch_op,
  input  logic            ex_zero,
  input  logic            ex_lt,
  input  logic            ex_ltu,
  input  logic [XLEN-1:0] ex_imm,
  input  logic [XLEN-1:0] ex_rs1,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  output logic [XLEN-1:0] pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  output logic            flush,
  output logic            misalign
);

  localparam int IDX   = $clog2(BTB_DEPTH);
  localparam int TAG_W = XLEN - IDX - 2;

  typedef logic [IDX-1:0]   idx_t;
  typedef logic [TAG_W-1:0] tag_t;

  typedef enum logic [2:0] {
    OP_BEQ  = 3'b000,
    OP_BNE  = 3'b001,
    OP_BLT  = 3'b100,
    OP_BGE  = 3'b101,
    OP_BLTU = 3'b110,
    OP_BGEU = 3'b111
  } br_op_e;

  // BTB storage
  logic [BTB_DEPTH-1:0] btb_valid;
  tag_t                 btb_tag    [BTB_DEPTH];
  logic [XLEN-1:0]      btb_target [BTB_DEPTH];
  logic [1:0]           btb_cnt    [BTB_DEPTH];

  // Lookup on the current fetch PC
  idx_t rd_idx;
  tag_t rd_tag;

  assign rd_idx      = pc[IDX+1:2];
  assign rd_tag      = pc[XLEN-1:IDX+2];
  assign pred_taken  = btb_valid[rd_idx] && (btb_tag[rd_idx] == rd_tag) && btb_cnt[rd_idx][1];
  assign pred_target = btb_target[rd_idx];

  // EX resolution
  logic            is_ctrl;
  logic            cond;
  logic            taken;
  logic [XLEN-1:0] br_sum;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] target;
  logic            mispredict;
  logic [XLEN-1:0] redirect_pc;

  assign is_ctrl  = ex_is_branch | ex_is_jal | ex_is_jalr;
  assign br_sum   = ex_pc + ex_imm;
  assign jalr_sum = ex_rs1 + ex_imm;

  // NOTE: every signal written in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    cond = 1'b0;
    case (br_op_e'(ex_branch_op))
      OP_BEQ:  cond = ex_zero;
      OP_BNE:  cond = !ex_zero;
      OP_BLT:  cond = ex_lt;
      OP_BGE:  cond = !ex_lt;
      OP_BLTU: cond = ex_ltu;
      OP_BGEU: cond = !ex_ltu;
      default: cond = 1'b0;
    endcase
  end

  always_comb begin
    taken       = ex_is_jal | ex_is_jalr | (ex_is_branch & cond);
    target      = ex_is_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : br_sum;
    misalign    = ex_valid & taken & (target[1:0] != 2'b00);
    mispredict  = ex_valid & ((taken != ex_pred_taken) |
                              (taken & (target != ex_pred_target)));
    flush       = mispredict | misalign;
    redirect_pc = ex_pc + XLEN'(4);
    if (misalign) begin
      redirect_pc = TRAP_PC;
    end else if (taken) begin
      redirect_pc = target;
    end
  end

  // BTB update decode, indexed and tagged by the EX PC
  idx_t wr_idx;
  tag_t wr_tag;
  logic wr_hit;
  logic upd_en;
  logic alloc;
  logic inval;

  assign wr_idx = ex_pc[IDX+1:2];
  assign wr_tag = ex_pc[XLEN-1:IDX+2];
  assign wr_hit = btb_valid[wr_idx] && (btb_tag[wr_idx] == wr_tag);
  assign upd_en = ex_valid && is_ctrl && !misalign;
  assign alloc  = upd_en && !wr_hit && taken;
  // A non-control instruction hitting an entry means the entry aliases it.
  assign inval  = ex_valid && !is_ctrl && wr_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btb_valid <= '0;
    end else if (alloc) begin
      btb_valid[wr_idx] <= 1'b1;
    end else if (inval) begin
      btb_valid[wr_idx] <= 1'b0;
    end
  end

  // NOTE: tag/target/counter arrays are deliberately not reset; the valid
  // bits gate every use, so only they need clearing.
  always_ff @(posedge clk) begin
    if (alloc) begin
      btb_tag[wr_idx]    <= wr_tag;
      btb_target[wr_idx] <= target;
      btb_cnt[wr_idx]    <= (ex_is_jal | ex_is_jalr) ? 2'b11 : 2'b10;
    end else if (upd_en && wr_hit) begin
      if (taken) begin
        btb_target[wr_idx] <= target;
        if (btb_cnt[wr_idx] != 2'b11) begin
          btb_cnt[wr_idx] <= btb_cnt[wr_idx] + 2'b01;
        end
      end else if (btb_cnt[wr_idx] != 2'b00) begin
        btb_cnt[wr_idx] <= btb_cnt[wr_idx] - 2'b01;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (flush) begin
      pc <= redirect_pc;
    end else if (stall) begin
      pc <= pc;
    end else if (pred_taken) begin
      pc <= pred_target;
    end else begin
      pc <= pc + XLEN'(4);
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: resolution vector table plus hand-written
// BTB/stall/reset sequences, with next-PC expectations queued per cycle.
module tb_pc_gen;

  localparam logic [31:0] RESET_PC = 32'h0;
  localparam logic [31:0] TRAP_PC  = 32'h100;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic        ex_is_branch;
  logic        ex_is_jal;
  logic        ex_is_jalr;
  logic [2:0]  ex_branch_op;
  logic        ex_zero;
  logic        ex_lt;
  logic        ex_ltu;
  logic [31:0] ex_imm;
  logic [31:0] ex_rs1;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic [31:0] pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        flush;
  logic        misalign;

  pc_gen #(
    .XLEN(32), .RESET_PC(RESET_PC), .TRAP_PC(TRAP_PC), .BTB_DEPTH(16)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_is_branch(ex_is_branch), .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr),
    .ex_branch_op(ex_branch_op), .ex_zero(ex_zero), .ex_lt(ex_lt), .ex_ltu(ex_ltu),
    .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_pred_taken(ex_pred_taken),
    .ex_pred_target(ex_pred_target), .pc(pc), .pred_taken(pred_taken),
    .pred_target(pred_target), .flush(flush), .misalign(misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v, br, jal, jalr;
    logic [2:0]  op;
    logic        z, lt, ltu;
    logic [31:0] epc, imm, rs1;
    logic        pt;
    logic [31:0] ptgt;
    logic        e_flush, e_mis;
    logic [31:0] e_redir;
  } vec_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_pc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_ex();
    ex_valid = 0; ex_pc = '0; ex_is_branch = 0; ex_is_jal = 0; ex_is_jalr = 0;
    ex_branch_op = '0; ex_zero = 0; ex_lt = 0; ex_ltu = 0; ex_imm = '0; ex_rs1 = '0;
    ex_pred_taken = 0; ex_pred_target = '0;
  endtask

  task automatic ex_drive(input logic br, input logic jal, input logic jalr,
                          input logic [2:0] op, input logic z, input logic lt,
                          input logic ltu, input logic [31:0] epc,
                          input logic [31:0] imm, input logic [31:0] rs1,
                          input logic pt, input logic [31:0] ptgt);
    ex_valid = 1; ex_is_branch = br; ex_is_jal = jal; ex_is_jalr = jalr;
    ex_branch_op = op; ex_zero = z; ex_lt = lt; ex_ltu = ltu; ex_pc = epc;
    ex_imm = imm; ex_rs1 = rs1; ex_pred_taken = pt; ex_pred_target = ptgt;
  endtask

  // Queue the expected post-edge PC, advance one edge, then compare.
  task automatic cycle(input string name, input logic [31:0] exp_next);
    logic [31:0] e;
    exp_q.push_back(exp_next);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check(name, pc, e);
  endtask

  // Redirect fetch via a mispredicted not-taken BEQ just before the target.
  task automatic redirect_to(input logic [31:0] tgt);
    ex_drive(1, 0, 0, 3'b000, 0, 0, 0, tgt - 32'h4, 32'h40, '0, 1, tgt + 32'h40);
    #1;
    check("redir_flush", 32'(flush), 32'd1);
    cycle("redir_pc", tgt);
    clear_ex();
  endtask

  vec_t tbl[18];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{1,1,0,0,3'b000,1,0,0, 32'h100,32'h20,0,          0,0,          1,0,32'h120};
    tbl[1]  = '{1,1,0,0,3'b000,0,0,0, 32'h100,32'h20,0,          0,0,          0,0,0};
    tbl[2]  = '{1,1,0,0,3'b001,0,0,0, 32'h200,32'hFFFF_FFF8,0,   1,32'h1F8,    0,0,0};
    tbl[3]  = '{1,1,0,0,3'b001,1,0,0, 32'h200,32'hFFFF_FFF8,0,   1,32'h1F8,    1,0,32'h204};
    tbl[4]  = '{1,1,0,0,3'b100,0,1,0, 32'h300,32'h10,0,          1,32'h400,    1,0,32'h310};
    tbl[5]  = '{1,1,0,0,3'b101,0,1,0, 32'h300,32'h10,0,          0,0,          0,0,0};
    tbl[6]  = '{1,1,0,0,3'b110,0,0,1, 32'h400,32'h6,0,           0,0,          1,1,32'h100};
    tbl[7]  = '{1,1,0,0,3'b111,0,0,0, 32'h500,32'h40,0,          0,0,          1,0,32'h540};
    tbl[8]  = '{1,1,0,0,3'b010,1,1,1, 32'h600,32'h8,0,           0,0,          0,0,0};
    tbl[9]  = '{1,0,1,0,3'b000,0,0,0, 32'h700,32'h100,0,         1,32'h800,    0,0,0};
    tbl[10] = '{1,0,0,1,3'b000,0,0,0, 32'h900,32'h4,32'h1001,    0,0,          1,0,32'h1004};
    tbl[11] = '{1,0,0,1,3'b000,0,0,0, 32'h900,32'h4,32'h1002,    0,0,          1,1,32'h100};
    tbl[12] = '{0,0,1,0,3'b000,0,0,0, 32'hA00,32'h4,0,           1,32'h1234,   0,0,0};
    tbl[13] = '{1,0,0,0,3'b000,1,0,0, 32'hA00,32'h4,0,           0,0,          0,0,0};
    tbl[14] = '{1,0,1,0,3'b000,0,0,0, 32'hFFFF_FFFC,32'h8,0,     0,0,          1,0,32'h4};
    tbl[15] = '{1,1,0,0,3'b000,0,0,0, 32'hFFFF_FFFC,32'h8,0,     1,32'h4,      1,0,32'h0};
    tbl[16] = '{1,0,0,1,3'b000,0,0,0, 32'hB00,32'h0,32'h1003,    0,0,          1,1,32'h100};
    tbl[17] = '{1,1,0,0,3'b101,0,0,0, 32'h300,32'h10,0,          1,32'h310,    0,0,0};

    // Reset with stall held so the table phase only moves PC on flush.
    rst = 1; stall = 1; clear_ex();
    @(posedge clk); @(posedge clk); #1;
    check("rst_pc", pc, RESET_PC);
    check("rst_pred", 32'(pred_taken), 32'd0);
    check("rst_flush", 32'(flush), 32'd0);
    check("rst_misalign", 32'(misalign), 32'd0);
    rst = 0;
    model_pc = RESET_PC;

    for (int i = 0; i < 18; i++) begin
      logic [31:0] e;
      ex_drive(tbl[i].br, tbl[i].jal, tbl[i].jalr, tbl[i].op, tbl[i].z, tbl[i].lt,
               tbl[i].ltu, tbl[i].epc, tbl[i].imm, tbl[i].rs1, tbl[i].pt, tbl[i].ptgt);
      ex_valid = tbl[i].v;
      #1;
      check($sformatf("vec%0d_flush", i), 32'(flush), 32'(tbl[i].e_flush));
      check($sformatf("vec%0d_misalign", i), 32'(misalign), 32'(tbl[i].e_mis));
      e = tbl[i].e_flush ? tbl[i].e_redir : model_pc;
      cycle($sformatf("vec%0d_pc", i), e);
      model_pc = e;
    end
    clear_ex();

    // Asynchronous reset mid-cycle, then free-running fetch.
    rst = 1;
    #1;
    check("async_rst_pc", pc, RESET_PC);
    @(posedge clk); #1;
    rst = 0; stall = 0;
    check("seq_pc0", pc, 32'h0);
    check("seq_pred0", 32'(pred_taken), 32'd0);
    cycle("seq_pc4", 32'h4);
    check("seq_pred4", 32'(pred_taken), 32'd0);
    cycle("seq_pc8", 32'h8);
    check("seq_pred8", 32'(pred_taken), 32'd0);
    cycle("seq_pc12", 32'hC);
    check("seq_pred12", 32'(pred_taken), 32'd0);

    // Cold BEQ at 0x10 taken to 0x30: flush and allocate with counter 10.
    ex_drive(1, 0, 0, 3'b000, 1, 0, 0, 32'h10, 32'h20, '0, 0, '0);
    #1;
    check("cold_beq_flush", 32'(flush), 32'd1);
    cycle("cold_beq_pc", 32'h30);
    clear_ex();
    redirect_to(32'h10);
    check("btb_hit_pred", 32'(pred_taken), 32'd1);
    check("btb_hit_target", pred_target, 32'h30);
    cycle("pred_zero_bubble", 32'h30);
    redirect_to(32'h10);
    ex_drive(1, 0, 0, 3'b000, 0, 0, 0, 32'h10, 32'h20, '0, 1, 32'h30);
    #1;
    check("same_idx_old_pred", 32'(pred_taken), 32'd1);
    check("beq_nt_flush", 32'(flush), 32'd1);
    cycle("beq_nt_pc", 32'h14);
    clear_ex();
    redirect_to(32'h10);
    check("cnt01_pred", 32'(pred_taken), 32'd0);
    cycle("cnt01_seq", 32'h14);

    // JALR: bit 0 cleared; bit 1 set traps and leaves the BTB alone.
    ex_drive(0, 0, 1, 3'b000, 0, 0, 0, 32'h40, 32'h4, 32'h1001, 0, '0);
    #1;
    check("jalr_misalign0", 32'(misalign), 32'd0);
    check("jalr_flush", 32'(flush), 32'd1);
    cycle("jalr_pc", 32'h1004);
    ex_drive(0, 0, 1, 3'b000, 0, 0, 0, 32'h40, 32'h4, 32'h1002, 0, '0);
    #1;
    check("jalr_misalign1", 32'(misalign), 32'd1);
    check("jalr_trap_flush", 32'(flush), 32'd1);
    cycle("jalr_trap_pc", TRAP_PC);
    clear_ex();
    redirect_to(32'h40);
    check("jalr_btb_pred", 32'(pred_taken), 32'd1);
    check("jalr_btb_target", pred_target, 32'h1004);

    // Stall holds over a predicted-taken PC; a flush overrides the stall.
    stall = 1;
    for (int k = 0; k < 3; k++) cycle($sformatf("stall_hold%0d", k), 32'h40);
    ex_drive(1, 0, 0, 3'b000, 1, 0, 0, 32'h80, 32'h10, '0, 0, '0);
    #1;
    check("stall_flush", 32'(flush), 32'd1);
    cycle("stall_redirect", 32'h90);
    clear_ex();
    stall = 0;
    cycle("post_stall", 32'h94);

    // Alias: non-control instruction hitting an entry invalidates it.
    redirect_to(32'h80);
    check("alias_pred_before", 32'(pred_taken), 32'd1);
    check("alias_target_before", pred_target, 32'h90);
    ex_drive(0, 0, 0, 3'b000, 0, 0, 0, 32'h80, '0, '0, 1, 32'h90);
    #1;
    check("alias_flush", 32'(flush), 32'd1);
    cycle("alias_pc", 32'h84);
    clear_ex();
    redirect_to(32'h80);
    check("alias_pred_after", 32'(pred_taken), 32'd0);
    cycle("alias_seq", 32'h84);

    // Allocate a JAL entry, then reset mid-run and confirm it is gone.
    ex_drive(0, 1, 0, 3'b000, 0, 0, 0, 32'h8, 32'h100, '0, 0, '0);
    #1;
    check("jal_flush", 32'(flush), 32'd1);
    cycle("jal_pc", 32'h108);
    clear_ex();
    rst = 1;
    #1;
    check("midrun_rst_pc", pc, RESET_PC);
    check("midrun_rst_pred", 32'(pred_taken), 32'd0);
    check("midrun_rst_flush", 32'(flush), 32'd0);
    @(posedge clk); #1;
    rst = 0;
    cycle("post_rst_pc4", 32'h4);
    cycle("post_rst_pc8", 32'h8);
    check("post_rst_miss", 32'(pred_taken), 32'd0);
    cycle("post_rst_pc12", 32'hC);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
